// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: RV32M funct3 op encodings, FSM state encoding, default operand width.
// No logic; imported by muldiv_unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: result valid XLEN+1 cycles after accept; div-by-zero / signed overflow in 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one bubble between ops).
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready with op, a, b;
//        out_valid/out_ready with result, div_zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state, state_next;
  op_e              op_in, op_q;
  logic             neg_q, neg_r;   // quotient/product sign, remainder sign
  logic [CNT_W-1:0] cnt;
  // Multiply: hi:lo is the product, lo starts as the multiplier, opnd is the multiplicand.
  // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in, opnd is the divisor.
  logic [XLEN-1:0]  hi, lo, opnd;

  assign op_in     = op_e'(op);
  assign in_ready  = (state == S_IDLE) && rst_n;
  assign out_valid = (state == S_DONE);

  // ---- accept-time operand conditioning and fast path ----
  logic            a_sgn, b_sgn, a_neg, b_neg, fast, fast_dz;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    a_sgn    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_sgn && a[XLEN-1];
    b_neg    = b_sgn && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    fast     = 1'b0;
    fast_dz  = 1'b0;
    fast_res = '0;
    if (op_in[2] && (b == '0)) begin
      fast     = 1'b1;
      fast_dz  = 1'b1;
      fast_res = op_in[1] ? a : '1;
    end else if ((op_in == OP_DIV || op_in == OP_REM) && (a == MOST_NEG) && (b == '1)) begin
      fast     = 1'b1;
      fast_res = op_in[1] ? '0 : a;
    end
  end

  // ---- one iteration step ----
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, div_rem_n, div_quo_n, step_hi, step_lo, final_res;
  logic [2*XLEN-1:0] prod_full, prod_fix;
  logic              div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], lo[XLEN-1:1]};
    rem_sh    = {hi, lo[XLEN-1]};
    div_diff  = rem_sh - {1'b0, opnd};
    div_ge    = !div_diff[XLEN];   // no borrow: shifted remainder >= divisor
    div_rem_n = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_quo_n = {lo[XLEN-2:0], div_ge};
    step_hi   = op_q[2] ? div_rem_n : mul_hi_n;
    step_lo   = op_q[2] ? div_quo_n : mul_lo_n;
    // Negate the full double-width product so the high half is correct for signed ops.
    prod_full = {mul_hi_n, mul_lo_n};
    prod_fix  = neg_q ? -prod_full : prod_full;
    unique case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = neg_q ? -div_quo_n : div_quo_n;
      default:                       final_res = neg_r ? -div_rem_n : div_rem_n;
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_next = fast ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == CNT_W'(1)) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle accept.
    if (flush) state_next = S_IDLE;
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (!flush) begin
      if (state == S_IDLE && in_valid) begin
        op_q  <= op_in;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt   <= CNT_W'(XLEN);
        hi    <= '0;
        lo    <= op_in[2] ? a_mag : b_mag;
        opnd  <= op_in[2] ? b_mag : a_mag;
        if (fast) begin
          result   <= fast_res;
          div_zero <= fast_dz;
        end
      end else if (state == S_BUSY) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          result   <= final_res;
          div_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN = 32): directed ops, random ops vs arithmetic model,
// back-pressure, flush and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {div_zero, result} from plain 64-bit / signed arithmetic.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic        ovf;
    logic [31:0] r;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'h0, x};
    uy  = {32'h0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = '0;
    p   = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: r = (y == 0) ? x : x % y;
    endcase
    return {(o[2] && y == 0), r};
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0)) return 1;
    if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge where out_valid is first seen.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_res, input logic exp_dz);
    int lat;
    issue(o, x, y, lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(o, x, y)));
    consume();
    check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [32:0] m;
    logic [31:0] held, x, y;
    logic [2:0]  o;
    int          lat;
    logic        seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);

    // Directed test-plan ops.
    run_check("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_check("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_check("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    run_check("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_check("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_check("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    run_check("divu",   3'd5, 32'd100,        32'd7,         32'd14,        1'b0);
    run_check("remu",   3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
    run_check("div0",   3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
    run_check("rem0",   3'd6, 32'd5,          32'd0,         32'd5,         1'b1);
    run_check("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_check("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b0);

    // Random ops against the model.
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      m = model(o, x, y);
      run_check($sformatf("rnd%0d_op%0d", i, o), o, x, y, m[31:0], m[32]);
    end

    // Back-pressure: hold 10 cycles, then back-to-back second op.
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    held = result;
    check("bp_first_res", held, 32'h0B00_EA4E);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", result, held);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    consume();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    issue(3'd0, 32'd1000, 32'hFFFF_FFFE, lat);
    check("bp_second_res", result, 32'hFFFF_F830);
    check("bp_second_lat", 32'(lat), 32'd33);
    consume();

    // Flush in cycle 10 of a DIV.
    in_valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    @(negedge clk);                         // cycle 1
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;                           // cycle 10
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    seen = out_valid;
    for (int i = 0; i < 40; i++) begin @(negedge clk); seen = seen | out_valid; end
    check("flush_no_valid", 32'(seen), 32'd0);

    // flush together with in_valid in IDLE: no accept.
    in_valid = 1'b1; flush = 1'b1; op = 3'd4; a = 32'd9; b = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc_in_ready", 32'(in_ready), 32'd1);
    seen = out_valid;
    for (int i = 0; i < 40; i++) begin @(negedge clk); seen = seen | out_valid; end
    check("flush_acc_no_valid", 32'(seen), 32'd0);

    // Reset mid-MUL.
    in_valid = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_in_ready_after", 32'(in_ready), 32'd1);
    check("mrst_out_valid_after", 32'(out_valid), 32'd0);
    run_check("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
